// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller.
// Tear-free frame latching, leading-zero blanking and per-slot guard.
module seg7_scan_ctrl #(
  parameter int TICKS    = 100000,
  parameter int GUARD    = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        frame_start
);

  localparam int CW = $clog2(TICKS);
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);
  localparam logic [CW-1:0] GRD  = CW'(GUARD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pending_q, pending_d;
  logic [15:0]   shown_q, shown_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          fs_q, fs_d;

  logic          wrap;
  logic [3:0]    nib;

  function automatic logic [6:0] glyph(
    input logic [3:0] h
  );
    logic [6:0] g;
    case (h)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Digit k is lit only if some digit at or above k is non-zero.
  function automatic logic visible(
    input logic [1:0]  i,
    input logic [15:0] v
  );
    logic vis;
    if (!BLANK_LZ) begin
      vis = 1'b1;
    end else begin
      case (i)
        2'd0:    vis = 1'b1;
        2'd1:    vis = |v[15:4];
        2'd2:    vis = |v[15:8];
        default: vis = |v[15:12];
      endcase
    end
    return vis;
  endfunction

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    shown_d   = shown_q;
    fs_d      = 1'b0;
    an_d      = 4'hF;
    seg_d     = 7'h7F;
    wrap      = (cnt_q == LAST);
    nib       = 4'h0;

    if (load) begin
      pending_d = value;
    end

    if (!en) begin
      cnt_d   = '0;
      idx_d   = 2'd0;
      shown_d = pending_d;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (wrap) begin
        idx_d = idx_q + 2'd1;
      end
      // A load on the boundary cycle lands straight in the new frame.
      if (wrap && idx_q == 2'd3) begin
        shown_d = pending_d;
        fs_d    = 1'b1;
      end
      nib = shown_d[{idx_d, 2'b00} +: 4];
      if (cnt_d >= GRD && visible(idx_d, shown_d)) begin
        an_d  = ~(4'b0001 << idx_d);
        seg_d = glyph(nib);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      pending_q <= 16'h0000;
      shown_q   <= 16'h0000;
      an_q      <= 4'hF;
      seg_q     <= 7'h7F;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      shown_q   <= shown_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      fs_q      <= fs_d;
    end
  end

  assign AN          = an_q;
  assign SEG         = seg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with TICKS=4, GUARD=1.
// A second instance runs with leading-zero blanking off.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] value;
  logic        load;
  logic [3:0]  an1, an2;
  logic [6:0]  seg1, seg2;
  logic        fs1, fs2;

  int errors = 0;
  int checks = 0;

  logic [6:0] gl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_ctrl #(
    .TICKS(4), .GUARD(1), .BLANK_LZ(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .en(en),
    .value(value), .load(load),
    .AN(an1), .SEG(seg1), .frame_start(fs1)
  );

  seg7_scan_ctrl #(
    .TICKS(4), .GUARD(1), .BLANK_LZ(1'b0)
  ) dut2 (
    .clk(clk), .reset(reset), .en(en),
    .value(value), .load(load),
    .AN(an2), .SEG(seg2), .frame_start(fs2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [15:0] v);
    en    = 1'b0;
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b0;
    load  = 1'b0;
    value = 16'h0;
    step();
    step();
    checks++;
    if (an1 !== 4'hF || seg1 !== 7'h7F || fs1 !== 1'b0) begin
      errors++;
      $display("FAIL reset AN=%b SEG=%b fs=%b exp 1111 1111111 0",
               an1, seg1, fs1);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan_1234();
    int t [4] = '{4, 3, 2, 1};
    logic [3:0] ean;
    logic [6:0] eseg;
    int c, d;
    setup(16'h1234);
    checks++;
    if (an1 !== 4'hF || seg1 !== 7'h7F) begin
      errors++;
      $display("FAIL scan_guard0 AN=%b SEG=%b exp 1111 1111111", an1, seg1);
    end
    for (int n = 1; n <= 16; n++) begin
      step();
      c = n % 4;
      d = (n / 4) % 4;
      if (c == 0) begin
        ean = 4'hF; eseg = 7'h7F;
      end else begin
        ean = ~(4'b0001 << d); eseg = gl[t[d]];
      end
      checks++;
      if (an1 !== ean || seg1 !== eseg) begin
        errors++;
        $display("FAIL scan n=%0d AN=%b SEG=%b exp %b %b",
                 n, an1, seg1, ean, eseg);
      end
      checks++;
      if (fs1 !== (n == 16)) begin
        errors++;
        $display("FAIL scan_fs n=%0d fs=%b exp %b", n, fs1, n == 16);
      end
    end
  endtask

  task automatic test_blank();
    int t1 [4] = '{5, -1, -1, -1};
    int t2 [4] = '{5, 0, 0, 0};
    logic [3:0] e1, e2;
    logic [6:0] s1, s2;
    int c, d;
    setup(16'h0005);
    for (int n = 1; n <= 16; n++) begin
      step();
      c = n % 4;
      d = (n / 4) % 4;
      e1 = 4'hF; s1 = 7'h7F;
      e2 = 4'hF; s2 = 7'h7F;
      if (c != 0 && t1[d] >= 0) begin
        e1 = ~(4'b0001 << d); s1 = gl[t1[d]];
      end
      if (c != 0) begin
        e2 = ~(4'b0001 << d); s2 = gl[t2[d]];
      end
      checks++;
      if (an1 !== e1 || seg1 !== s1) begin
        errors++;
        $display("FAIL blank_lz n=%0d AN=%b SEG=%b exp %b %b",
                 n, an1, seg1, e1, s1);
      end
      checks++;
      if (an2 !== e2 || seg2 !== s2) begin
        errors++;
        $display("FAIL blank_off n=%0d AN=%b SEG=%b exp %b %b",
                 n, an2, seg2, e2, s2);
      end
    end
  endtask

  task automatic test_midframe_update();
    int t [2][4] = '{'{13, 12, 11, 10}, '{15, 14, -1, -1}};
    logic [3:0] ean;
    logic [6:0] eseg;
    int c, d, f;
    setup(16'hABCD);
    for (int n = 1; n <= 32; n++) begin
      if (n == 6) begin
        value = 16'h00EF; load = 1'b1;
      end
      step();
      load = 1'b0;
      c = n % 4;
      d = (n / 4) % 4;
      f = (n / 16) % 2;
      ean = 4'hF; eseg = 7'h7F;
      if (c != 0 && t[f][d] >= 0) begin
        ean = ~(4'b0001 << d); eseg = gl[t[f][d]];
      end
      checks++;
      if (an1 !== ean || seg1 !== eseg) begin
        errors++;
        $display("FAIL midframe n=%0d AN=%b SEG=%b exp %b %b",
                 n, an1, seg1, ean, eseg);
      end
      checks++;
      if (fs1 !== (n % 16 == 0)) begin
        errors++;
        $display("FAIL midframe_fs n=%0d fs=%b exp %b",
                 n, fs1, n % 16 == 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t [3][4] = '{'{1, -1, -1, -1}, '{8, 8, 8, 8}, '{2, 4, -1, -1}};
    logic [3:0] ean;
    logic [6:0] eseg;
    int c, d, f;
    setup(16'h0001);
    for (int n = 1; n <= 47; n++) begin
      if (n == 16) begin
        value = 16'h8888; load = 1'b1;
      end else if (n == 18) begin
        value = 16'h1111; load = 1'b1;
      end else if (n == 22) begin
        value = 16'h0042; load = 1'b1;
      end
      step();
      load = 1'b0;
      c = n % 4;
      d = (n / 4) % 4;
      f = n / 16;
      ean = 4'hF; eseg = 7'h7F;
      if (c != 0 && t[f][d] >= 0) begin
        ean = ~(4'b0001 << d); eseg = gl[t[f][d]];
      end
      checks++;
      if (an1 !== ean || seg1 !== eseg) begin
        errors++;
        $display("FAIL boundary n=%0d AN=%b SEG=%b exp %b %b",
                 n, an1, seg1, ean, eseg);
      end
      checks++;
      if (fs1 !== (n == 16 || n == 32)) begin
        errors++;
        $display("FAIL boundary_fs n=%0d fs=%b exp %b",
                 n, fs1, n == 16 || n == 32);
      end
    end
  endtask

  task automatic test_disable();
    int t [4] = '{4, 3, 2, 1};
    logic [3:0] ean;
    logic [6:0] eseg;
    int c, d;
    setup(16'h1234);
    for (int n = 1; n <= 9; n++) step();
    checks++;
    if (an1 !== 4'b1011 || seg1 !== gl[2]) begin
      errors++;
      $display("FAIL dis_pre AN=%b SEG=%b exp 1011 %b", an1, seg1, gl[2]);
    end
    en = 1'b0;
    step();
    checks++;
    if (an1 !== 4'hF || seg1 !== 7'h7F || fs1 !== 1'b0) begin
      errors++;
      $display("FAIL dis_dark AN=%b SEG=%b fs=%b exp 1111 1111111 0",
               an1, seg1, fs1);
    end
    step();
    en = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      c = n % 4;
      d = (n / 4) % 4;
      ean = 4'hF; eseg = 7'h7F;
      if (c != 0) begin
        ean = ~(4'b0001 << d); eseg = gl[t[d]];
      end
      checks++;
      if (an1 !== ean || seg1 !== eseg) begin
        errors++;
        $display("FAIL reen n=%0d AN=%b SEG=%b exp %b %b",
                 n, an1, seg1, ean, eseg);
      end
      checks++;
      if (fs1 !== (n == 16)) begin
        errors++;
        $display("FAIL reen_fs n=%0d fs=%b exp %b", n, fs1, n == 16);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ean;
    logic [6:0] eseg;
    int c, d;
    setup(16'hFFFF);
    for (int n = 1; n <= 6; n++) step();
    checks++;
    if (an1 !== 4'b1101 || seg1 !== gl[15]) begin
      errors++;
      $display("FAIL rmid_pre AN=%b SEG=%b exp 1101 %b", an1, seg1, gl[15]);
    end
    reset = 1'b1;
    value = 16'h1234;
    load  = 1'b1;
    step();
    load  = 1'b0;
    checks++;
    if (an1 !== 4'hF || seg1 !== 7'h7F || fs1 !== 1'b0) begin
      errors++;
      $display("FAIL rmid_dark AN=%b SEG=%b fs=%b exp 1111 1111111 0",
               an1, seg1, fs1);
    end
    reset = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      c = n % 4;
      d = (n / 4) % 4;
      ean = 4'hF; eseg = 7'h7F;
      if (c != 0 && d == 0) begin
        ean = 4'b1110; eseg = gl[0];
      end
      checks++;
      if (an1 !== ean || seg1 !== eseg) begin
        errors++;
        $display("FAIL rmid n=%0d AN=%b SEG=%b exp %b %b",
                 n, an1, seg1, ean, eseg);
      end
      if (n == 5) begin
        checks++;
        if (an2 !== 4'b1101 || seg2 !== gl[0]) begin
          errors++;
          $display("FAIL rmid_nolz AN=%b SEG=%b exp 1101 %b",
                   an2, seg2, gl[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_blank();
    test_midframe_update();
    test_back_to_back();
    test_disable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
